shift_reg2d_param: RTL and testbench
====================================

Name: shift_reg2d_param

Overview:
- Parametrised successor to the fixed 16x4 tapped shift register.
- Holds DEPTH words of WIDTH bits, all visible in parallel.
- Adds shift enable, selectable direction, synchronous clear, saturating fill tracking and a registered random-access tap.
- Used as the delay line and sample window feeding the display and filter stages.

Parameters:
- WIDTH, 4: bits per stage.
- DEPTH, 16: number of stages, at least 2.
- AW, $clog2(DEPTH): tap-select width, derived; do not override.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- EN  input  1  shift strobe; one shift per cycle while high.
- DIR  input  1  0: data moves stage k to k+1, IN enters stage 0. 1: data moves stage k to k-1, IN enters stage DEPTH-1.
- CLR  input  1  synchronous clear of stages and fill count.
- ROT  input  1  rotate request; honoured only with the optional feature.
- IN  input  WIDTH  data word shifted in.
- TAP_SEL  input  AW  stage index for TAP_OUT.
- TAP_OUT  output  WIDTH  registered copy of the selected stage.
- OUT_ALL  output  WIDTH*DEPTH  all stages flattened; stage k occupies bits [k*WIDTH +: WIDTH].
- FILL  output  AW+1  valid-stage count, saturating at DEPTH.
- FULL  output  1  high when FILL == DEPTH.

Behaviour:
- Reset (RESETN low, asynchronous): all stages, TAP_OUT and FILL go to 0 immediately; FULL is 0. Release is sampled on the next rising CLK edge; no shift happens in the release cycle unless EN is high then.
- Priority per edge: CLR > EN > hold.
- CLR high: all stages go to 0 and FILL goes to 0. EN is ignored that cycle. TAP_OUT still samples (see below).
- EN high, DIR=0: stage[0] <= IN; stage[k] <= stage[k-1] for k = 1..DEPTH-1; stage[DEPTH-1] is discarded.
- EN high, DIR=1: stage[DEPTH-1] <= IN; stage[k] <= stage[k+1]; stage[0] is discarded.
- EN low: all stages hold.
- OUT_ALL is combinational from the stage registers: the new value is visible immediately after the edge, 0 cycles of added latency.
- TAP_OUT is registered every edge from the pre-edge value of stage[TAP_SEL]. Read latency is 1 cycle, and the value is the stage content before any shift on the same edge.
- TAP_SEL >= DEPTH (non-power-of-2 DEPTH): TAP_OUT <= 0.
- FILL increments by 1 on each EN shift (shift-in, not rotate) while FILL < DEPTH, then saturates at DEPTH.
- FILL is independent of DIR. Changing DIR mid-stream does not alter FILL or move data; later shifts simply go the other way.
- FULL = (FILL == DEPTH), combinational from FILL.
- Reset mid-operation discards all contents; there is no partial state.
- CLR and EN together: the clear wins and IN is lost.

Optional Feature:
- Macro: SHIFT_REG2D_ROTATE_EN.
- Defined: when EN=1 and ROT=1 (CLR=0), the outgoing end stage is fed back into the entry stage instead of IN.
  - DIR=0: stage[0] <= old stage[DEPTH-1].
  - DIR=1: stage[DEPTH-1] <= old stage[0].
  - FILL is unchanged on a rotate.
  - A rotate with FILL < DEPTH is allowed and circulates the zero/stale stages as well.
- Not defined: the ROT port is present but ignored. EN always shifts IN, and FILL counts as normal. Synthesis removes the feedback mux.

Test Plan (WIDTH=4, DEPTH=16):
- Reset then fill: assert RESETN low mid-cycle, then apply EN=1, DIR=0 with IN=1..16 over 16 cycles. Required: all outputs are 0 immediately after reset. After the sequence, OUT_ALL stage0=0x0 (16 mod 16), stage15=0x1, FILL=16, FULL=1. A 17th shift keeps FILL=16.
- Tap latency: with IN=0xA shifted into stage 0 on edge n, set TAP_SEL=0 before edge n. Required: TAP_OUT shows the pre-shift value after edge n and 0xA after edge n+1. TAP_SEL=15 returns stage15.
- Direction: fill with 0..15 (DIR=0), then one shift with DIR=1, IN=0xF. Required: stage15=0xF, stage k takes the old stage[k+1], old stage0 is lost, FILL stays 16.
- CLR priority: at FILL=5, apply CLR=1 and EN=1 with IN=0x7. Required: all stages 0, FILL=0, FULL=0, and 0x7 is absent.
- Hold: EN=0 for 10 cycles with IN toggling. Required: OUT_ALL and FILL are unchanged.
- Rotate (macro defined): fill 0..15, then EN=1, ROT=1, DIR=0 for 16 cycles. Required: OUT_ALL equals its original value and FILL=16. Without the macro, the same stimulus shifts IN in.

Source files
------------

// File: rtl/shift_reg2d_param.sv
// shift_reg2d_param: DEPTH x WIDTH parallel-visible shift register with direction, clear, fill tracking and registered tap.
// Optional rotate feedback is enabled by defining SHIFT_REG2D_ROTATE_EN.
module shift_reg2d_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   clr,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       in,
  input  logic [AW-1:0]          tap_sel,
  output logic [WIDTH-1:0]       tap_out,
  output logic [WIDTH*DEPTH-1:0] out_all,
  output logic [AW:0]            fill,
  output logic                   full
);
  localparam logic [AW:0] FMAX = (AW+1)'(DEPTH);
  logic [WIDTH*DEPTH-1:0] data, shifted;
  logic [WIDTH-1:0] feed, tap_val;
  logic count;
`ifdef SHIFT_REG2D_ROTATE_EN
  // A rotate recirculates the outgoing end stage and leaves the fill count alone.
  assign feed  = rot ? (dir ? data[WIDTH-1:0] : data[WIDTH*DEPTH-1 -: WIDTH]) : in;
  assign count = !rot;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign feed  = in;
  assign count = 1'b1;
`endif
  assign shifted = dir ? {feed, data[WIDTH*DEPTH-1:WIDTH]} : {data[WIDTH*(DEPTH-1)-1:0], feed};
  generate
    if (DEPTH == 2**AW) begin : g_pow2
      assign tap_val = data[tap_sel*WIDTH +: WIDTH];
    end else begin : g_npow2
      assign tap_val = ((AW+1)'(tap_sel) < FMAX) ? data[tap_sel*WIDTH +: WIDTH] : '0;
    end
  endgenerate
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data    <= '0;
      fill    <= '0;
      tap_out <= '0;
    end else begin
      tap_out <= tap_val;
      if (clr) begin
        data <= '0;
        fill <= '0;
      end else if (en) begin
        data <= shifted;
        if (count && fill != FMAX) fill <= fill + 1'b1;
      end
    end
  end
  assign out_all = data;
  assign full    = (fill == FMAX);
endmodule

// File: tb/tb_shift_reg2d_param.sv
// tb_shift_reg2d_param: randomized and directed checks of shift_reg2d_param against a stage-array model.
module tb_shift_reg2d_param;
  localparam int W = 4;
  localparam int D = 16;
  localparam int AW = $clog2(D);
`ifdef SHIFT_REG2D_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, en = 1'b0, dir = 1'b0, clr = 1'b0, rot = 1'b0;
  logic [W-1:0] in = '0;
  logic [AW-1:0] tap_sel = '0;
  logic [W-1:0] tap_out;
  logic [W*D-1:0] out_all;
  logic [AW:0] fill;
  logic full;
  int checks = 0, fails = 0;
  bit cmp_on = 1'b0;
  logic [W-1:0] m [D];
  logic [W-1:0] m_tap;
  int m_fill;

  shift_reg2d_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .clr(clr), .rot(rot),
    .in(in), .tap_sel(tap_sel), .tap_out(tap_out), .out_all(out_all),
    .fill(fill), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [W*D-1:0] model_flat();
    logic [W*D-1:0] v;
    for (int k = 0; k < D; k++) v[k*W +: W] = m[k];
    return v;
  endfunction

  // Reference: stage array updated from the rules, using pre-edge values.
  always @(posedge clk or negedge resetn) begin
    logic [W-1:0] old [D];
    bit r;
    if (!resetn) begin
      for (int k = 0; k < D; k++) m[k] = '0;
      m_fill = 0;
      m_tap = '0;
    end else begin
      old = m;
      m_tap = (int'(tap_sel) < D) ? old[tap_sel] : '0;
      r = ROT_ON && rot;
      if (clr) begin
        for (int k = 0; k < D; k++) m[k] = '0;
        m_fill = 0;
      end else if (en) begin
        if (!dir) begin
          for (int k = 1; k < D; k++) m[k] = old[k-1];
          m[0] = r ? old[D-1] : in;
        end else begin
          for (int k = 0; k < D-1; k++) m[k] = old[k+1];
          m[D-1] = r ? old[0] : in;
        end
        if (!r && m_fill < D) m_fill++;
      end
    end
  end

  task automatic check(input string name, input logic [W*D-1:0] act, input logic [W*D-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_out_all", out_all, model_flat());
      check("cyc_fill", (W*D)'(fill), (W*D)'(m_fill));
      check("cyc_full", (W*D)'(full), (W*D)'(m_fill == D));
      check("cyc_tap", (W*D)'(tap_out), (W*D)'(m_tap));
    end
  end

  task automatic step(input logic e, input logic d, input logic c, input logic r, input logic [W-1:0] i);
    en = e; dir = d; clr = c; rot = r; in = i;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] stg(input int k);
    return out_all[k*W +: W];
  endfunction

  initial begin
    logic [W*D-1:0] saved;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    cmp_on = 1'b1;
    @(posedge clk); #1;
    // Prime with data, then pull reset low mid-cycle.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'(i + 3));
    #2 resetn = 1'b0;
    #1;
    check("reset_out_all", out_all, '0);
    check("reset_fill", (W*D)'(fill), '0);
    check("reset_full", (W*D)'(full), '0);
    check("reset_tap", (W*D)'(tap_out), '0);
    @(posedge clk); #2 resetn = 1'b1;
    @(posedge clk); #1;
    // Fill with 1..16.
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, W'(i));
    check("fill_stage0", (W*D)'(stg(0)), 0);
    check("fill_stage15", (W*D)'(stg(15)), 1);
    check("fill_count", (W*D)'(fill), 16);
    check("fill_full", (W*D)'(full), 1);
    step(1, 0, 0, 0, 4'h5);
    check("fill_saturate", (W*D)'(fill), 16);
    // Tap latency: stage0 holds 5 before the edge that shifts in 0xA.
    tap_sel = '0;
    step(1, 0, 0, 0, 4'hA);
    check("tap_preshift", (W*D)'(tap_out), 5);
    step(0, 0, 0, 0, 4'h0);
    check("tap_new", (W*D)'(tap_out), 4'hA);
    tap_sel = 4'd15;
    step(0, 0, 0, 0, 4'h0);
    check("tap_sel15", (W*D)'(tap_out), (W*D)'(stg(15)));
    check("tap_sel15_lit", (W*D)'(tap_out), 3);
    // Direction change.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, W'(i));
    step(1, 1, 0, 0, 4'hF);
    check("dir_stage15", (W*D)'(stg(15)), 4'hF);
    check("dir_stage0", (W*D)'(stg(0)), 14);
    check("dir_stage14", (W*D)'(stg(14)), 0);
    check("dir_fill", (W*D)'(fill), 16);
    // Clear beats shift.
    step(0, 0, 1, 0, 4'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, W'(i + 1));
    check("clr_pre_fill", (W*D)'(fill), 5);
    step(1, 0, 1, 0, 4'h7);
    check("clr_out_all", out_all, '0);
    check("clr_fill", (W*D)'(fill), 0);
    check("clr_full", (W*D)'(full), 0);
    // Hold.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, W'(i + 9));
    saved = out_all;
    for (int i = 0; i < 10; i++) step(0, i[0], 0, 0, W'(i));
    check("hold_out_all", out_all, saved);
    check("hold_fill", (W*D)'(fill), 7);
    // Rotate.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, W'(i));
    saved = out_all;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 4'h3);
    if (ROT_ON) check("rot_out_all", out_all, saved);
    else check("rot_ignored", out_all, {D{4'h3}});
    check("rot_fill", (W*D)'(fill), 16);
    // Randomized traffic with occasional async reset.
    for (int n = 0; n < 3000; n++) begin
      tap_sel = AW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 3) == 0), W'($urandom));
    end
    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
